// File: rtl/credit_rtl.sv
// Valid/ready FIFO pipeline with credit-based flow control: upstream -> link register -> 2^A_WIDTH FIFO -> downstream.
// Optional macro RTL_CREDIT_RETURN_PIPE_EN delays credit return by one register stage.
module credit_rtl #(
    parameter int D_WIDTH      = 6,
    parameter int A_WIDTH      = 2,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(DEPTH);

    logic [CREDIT_WIDTH-1:0] credit;
    logic [D_WIDTH-1:0]      link_data;
    logic                    link_valid;
    logic [D_WIDTH-1:0]      mem [DEPTH];
    logic [A_WIDTH:0]        wr_ptr;
    logic [A_WIDTH:0]        rd_ptr;
    logic                    push;
    logic                    pop;
    logic                    credit_ret;
    logic                    empty;
    logic                    full;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]) &&
                        (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]);
    assign up_ready   = (credit != '0) && rst;
    assign down_valid = !empty;
    assign down_data  = mem[rd_ptr[A_WIDTH-1:0]];
    assign push       = up_valid && up_ready;
    assign pop        = down_valid && down_ready;

`ifdef RTL_CREDIT_RETURN_PIPE_EN
    logic ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ret_q <= 1'b0;
        else      ret_q <= pop;
    end

    assign credit_ret = ret_q;
`else
    assign credit_ret = pop;
`endif

    // Credits count every word outstanding in the link register and the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit <= CREDIT_MAX;
        end else if (push && !credit_ret) begin
            credit <= credit - 1'b1;
        end else if (!push && credit_ret) begin
            credit <= credit + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_valid <= 1'b0;
            link_data  <= '0;
        end else begin
            link_valid <= push;
            if (push) link_data <= up_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (link_valid) begin
                mem[wr_ptr[A_WIDTH-1:0]] <= link_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(link_valid && full));
    a_credit_range: assert property (@(posedge clk) disable iff (!rst) credit <= CREDIT_MAX);

endmodule

// File: tb/tb_credit_rtl.sv
// Directed bench for credit_rtl with a reference queue model of accepted-but-not-delivered words.
module tb_credit_rtl;

    logic       clk;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready;

    int checks = 0;
    int failures = 0;
    logic [5:0] q[$];
    logic [5:0] out_log[$];
    bit link_pending = 0;
    bit last_push = 0;
    int idx;

    credit_rtl #(.D_WIDTH(6), .A_WIDTH(2), .CREDIT_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: settle, score the handshakes against the model, then advance.
    task automatic step();
        bit push;
        bit pop;
        #1;
        push = up_valid && up_ready;
        pop  = down_valid && down_ready;
`ifndef RTL_CREDIT_RETURN_PIPE_EN
        check("credit_model", int'(dut.credit), 4 - q.size());
`else
        check("credit_range", int'(dut.credit <= 3'd4), 1);
`endif
        check("down_valid_model", int'(down_valid), int'((q.size() - int'(link_pending)) > 0));
        if (pop) begin
            if (q.size() == 0) begin
                check("pop_nonempty", 0, 1);
            end else begin
                check("pop_data", int'(down_data), int'(q[0]));
                out_log.push_back(down_data);
                void'(q.pop_front());
            end
        end
        if (push) q.push_back(up_data);
        link_pending = push;
        last_push = push;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        up_data = '0;
        up_valid = 1'b0;
        down_ready = 1'b0;

        // reset and idle
        @(posedge clk); @(posedge clk); #1;
        check("rst_up_ready", int'(up_ready), 0);
        check("rst_down_valid", int'(down_valid), 0);
        rst = 1'b1;
        #1;
        check("idle_up_ready", int'(up_ready), 1);
        check("idle_down_valid", int'(down_valid), 0);
        check("idle_down_data", int'(down_data), 0);
        check("idle_credit", int'(dut.credit), 4);

        // three-word stream, two edges of latency
        down_ready = 1'b1;
        up_valid = 1'b1; up_data = 6'h01;
        step();
        check("lat_dv0", int'(down_valid), 0);
        up_data = 6'h02;
        step();
        check("lat_dv1", int'(down_valid), 1);
        check("lat_dd1", int'(down_data), 1);
        up_data = 6'h03;
        step();
        check("lat_dd2", int'(down_data), 2);
        up_valid = 1'b0;
        step();
        check("lat_dd3", int'(down_data), 3);
        step();
        check("lat_empty", int'(down_valid), 0);
        step();
        check("lat_credit", int'(dut.credit), 4);

        // backpressure: exactly four words accepted, then drain in order
        out_log.delete();
        down_ready = 1'b0;
        up_valid = 1'b1;
        idx = 0;
        up_data = 6'h0A;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_push) begin idx++; up_data = 6'(10 + idx); end
        end
        check("bp_accepted", idx, 4);
        check("bp_up_ready", int'(up_ready), 0);
        check("bp_down_valid", int'(down_valid), 1);
        check("bp_hold_data", int'(down_data), 'h0A);
        check("bp_credit", int'(dut.credit), 0);
        down_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (idx == 6) up_valid = 1'b0;
            if (idx == 6 && q.size() == 0) break;
            step();
            if (last_push) begin idx++; up_data = 6'(10 + idx); end
        end
        check("bp_out_count", out_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_log.size()) check("bp_out_order", int'(out_log[i]), 'h0A + i);
        end
        step();
        step();

        // full FIFO, single pop: credit return timing
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_data = 6'(8'h21 + i);
            step();
        end
        up_valid = 1'b0;
        step();
        check("full_up_ready", int'(up_ready), 0);
        check("full_credit", int'(dut.credit), 0);
        down_ready = 1'b1;
        step();
        down_ready = 1'b0;
`ifdef RTL_CREDIT_RETURN_PIPE_EN
        check("pipe_ret_late", int'(up_ready), 0);
        step();
        check("pipe_ret_rise", int'(up_ready), 1);
`else
        check("ret_same_edge", int'(up_ready), 1);
`endif
        check("full_next_head", int'(down_data), 'h22);
        down_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("full_drained", int'(down_valid), 0);

        // random traffic against the model
        for (int i = 0; i < 1000; i++) begin
            up_valid = 1'($urandom_range(0, 1));
            down_ready = 1'($urandom_range(0, 1));
            up_data = 6'($urandom_range(0, 63));
            step();
        end

        // reset with three stored words
        up_valid = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_data = 6'(8'h31 + i);
            step();
        end
        up_valid = 1'b0;
        step();
        step();
        check("pre_rst_dv", int'(down_valid), 1);
        check("pre_rst_dd", int'(down_data), 'h31);
        rst = 1'b0;
        #1;
        check("mid_rst_dv", int'(down_valid), 0);
        check("mid_rst_up_ready", int'(up_ready), 0);
        check("mid_rst_dd", int'(down_data), 0);
        q.delete();
        link_pending = 0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("post_rst_up_ready", int'(up_ready), 1);
        check("post_rst_credit", int'(dut.credit), 4);
        check("post_rst_dv", int'(down_valid), 0);
        step();
        check("post_rst_idle_dv", int'(down_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
